// File: rtl/bp2wb_pkg.sv
// Shared types and helpers for the Wishbone <-> BlackParrot memory bridges:
// config selection, CCE memory message layout, bridge FSM states and sel decoding.
package bp2wb_pkg;

    typedef enum logic [1:0] {
        e_bp_single_core_cfg,
        e_bp_dual_core_cfg
    } bp_params_e;

    localparam int unsigned paddr_width_gp     = 40;
    localparam int unsigned cce_block_width_gp = 512;
    localparam int unsigned lce_id_width_gp    = 8;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'b0000,
        e_cce_mem_wr    = 4'b0001,
        e_cce_mem_uc_rd = 4'b0010,
        e_cce_mem_uc_wr = 4'b0011
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_size_1  = 3'b000,
        e_mem_size_2  = 3'b001,
        e_mem_size_4  = 3'b010,
        e_mem_size_8  = 3'b011,
        e_mem_size_16 = 3'b100,
        e_mem_size_32 = 3'b101,
        e_mem_size_64 = 3'b110
    } bp_mem_size_e;

    typedef struct packed {
        logic [lce_id_width_gp-1:0] lce_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        logic [cce_block_width_gp-1:0] data;
        bp_cce_mem_payload_s           payload;
        bp_mem_size_e                  size;
        logic [paddr_width_gp-1:0]     addr;
        bp_cce_mem_cmd_type_e          msg_type;
    } bp_cce_mem_msg_s;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait,
        StDone
    } bp2wb_state_e;

    // Both supported configs share one physical address width.
    function automatic int unsigned bp_paddr_width(bp_params_e cfg);
        case (cfg)
            e_bp_dual_core_cfg: return paddr_width_gp;
            default:            return paddr_width_gp;
        endcase
    endfunction

    // Byte count of a legal lane select, 0 when the pattern is not a naturally aligned access.
    function automatic int unsigned sel_bytes(logic [7:0] sel);
        case (sel)
            8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80: return 1;
            8'h03, 8'h0C, 8'h30, 8'hC0:                             return 2;
            8'h0F, 8'hF0:                                           return 4;
            8'hFF:                                                  return 8;
            default:                                                return 0;
        endcase
    endfunction

    function automatic logic sel_legal(logic [7:0] sel);
        return sel_bytes(sel) != 0;
    endfunction

    function automatic bp_mem_size_e size_enc(int unsigned bytes);
        case (bytes)
            1:       return e_mem_size_1;
            2:       return e_mem_size_2;
            4:       return e_mem_size_4;
            default: return e_mem_size_8;
        endcase
    endfunction

endpackage

// File: rtl/wb_sel_decode.sv
// Combinational Wishbone byte-select decode: legality, lowest-lane byte offset and BP size.
module wb_sel_decode
    import bp2wb_pkg::*;
(
    input  logic [7:0]   sel_i,
    output logic         legal_o,
    output logic [2:0]   offset_o,
    output bp_mem_size_e size_o
);

    always_comb begin
        legal_o  = sel_legal(sel_i);
        size_o   = size_enc(sel_bytes(sel_i));
        offset_o = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (sel_i[i]) offset_o = 3'(i);
        end
    end

endmodule

// File: rtl/wb2bp_convertor.sv
// Wishbone classic slave that turns each access into one uncached BP CCE memory command,
// waits for its response (bounded by a timeout) and terminates the Wishbone cycle.
module wb2bp_convertor
    import bp2wb_pkg::*;
#(
    parameter bp_params_e   bp_params_p          = e_bp_single_core_cfg,
    parameter int unsigned  timeout_cycles_p     = 1024,
    parameter int unsigned  lce_id_p             = 0,
    localparam int unsigned paddr_width_p        = bp_paddr_width(bp_params_p),
    localparam int unsigned cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s)
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [paddr_width_p-4:0]        adr_i,
    input  logic [63:0]                     dat_i,
    output logic [63:0]                     dat_o,
    input  logic [7:0]                      sel_i,
    input  logic                            we_i,
    input  logic                            cyc_i,
    input  logic                            stb_i,
    output logic                            ack_o,
    output logic                            err_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
    output logic                            mem_cmd_v_o,
    input  logic                            mem_cmd_ready_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
    input  logic                            mem_resp_v_i,
    output logic                            mem_resp_yumi_o
);

    localparam int unsigned CntW    = $clog2(timeout_cycles_p + 1);
    localparam int unsigned DataLsb = cce_mem_msg_width_lp - cce_block_width_gp;

    bp2wb_state_e    state_q, state_d;
    bp_cce_mem_msg_s cmd_q, cmd_d;
    logic [7:0]      sel_q, sel_d;
    logic [2:0]      offset_q, offset_d;
    logic            err_q, err_d;
    logic            abort_q, abort_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     dat_q, dat_d;
    logic [63:0]     lane_mask;
    logic            timeout_hit;
    logic            dec_legal;
    logic [2:0]      dec_offset;
    bp_mem_size_e    dec_size;
    logic            unused_resp;

    wb_sel_decode u_sel_decode (
        .sel_i    (sel_i),
        .legal_o  (dec_legal),
        .offset_o (dec_offset),
        .size_o   (dec_size)
    );

    // Only the low dword of the response block carries data for these accesses.
    assign unused_resp = ^mem_resp_i;
    assign mem_cmd_o   = cmd_q;
    assign dat_o       = dat_q;
    assign timeout_hit = (cnt_q == CntW'(timeout_cycles_p - 1));

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 8; i++) begin
            lane_mask[8*i +: 8] = {8{sel_q[i]}};
        end
    end

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        sel_d           = sel_q;
        offset_d        = offset_q;
        err_d           = err_q;
        abort_d         = abort_q;
        cnt_d           = cnt_q;
        dat_d           = dat_q;
        mem_cmd_v_o     = 1'b0;
        mem_resp_yumi_o = 1'b0;
        ack_o           = 1'b0;
        err_o           = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cyc_i && stb_i) begin
                    cmd_d                = '0;
                    cmd_d.msg_type       = we_i ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
                    cmd_d.addr           = {adr_i, dec_offset};
                    cmd_d.size           = dec_size;
                    cmd_d.payload.lce_id = lce_id_width_gp'(lce_id_p);
                    cmd_d.data           = cce_block_width_gp'(dat_i >> {dec_offset, 3'b000});
                    sel_d                = sel_i;
                    offset_d             = dec_offset;
                    err_d                = ~dec_legal;
                    abort_d              = 1'b0;
                    cnt_d                = '0;
                    state_d              = dec_legal ? StSend : StDone;
                end
            end
            StSend: begin
                if (!cyc_i) abort_d = 1'b1;
                // Withdraw the command in the timeout cycle so it cannot be accepted late.
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    mem_cmd_v_o = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    if (mem_cmd_ready_i) state_d = StWait;
                end
            end
            StWait: begin
                if (!cyc_i) abort_d = 1'b1;
                mem_resp_yumi_o = mem_resp_v_i;
                if (mem_resp_v_i) begin
                    dat_d   = (mem_resp_i[DataLsb +: 64] << {offset_q, 3'b000}) & lane_mask;
                    state_d = StDone;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                ack_o   = ~err_q & ~abort_q;
                err_o   = err_q & ~abort_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= StIdle;
            cmd_q    <= '0;
            sel_q    <= '0;
            offset_q <= '0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
            cnt_q    <= '0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            sel_q    <= sel_d;
            offset_q <= offset_d;
            err_q    <= err_d;
            abort_q  <= abort_d;
            cnt_q    <= cnt_d;
            dat_q    <= dat_d;
        end
    end

endmodule

// File: doc/wb2bp_convertor.md
WB2BP_CONVERTOR -- requirements
Module: wb2bp_convertor

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_single_core_cfg, selecting the BP config; paddr_width_p and cce_mem_msg_width_lp are derived from it.
REQ-002 SHALL have parameter timeout_cycles_p, default 1024, giving the maximum wait for mem_resp before a Wishbone error.
REQ-003 SHALL have parameter lce_id_p, default 0, the value placed in the cmd payload.
REQ-004 Ports, one per line:
- clk_i  in  1  sole clock.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- adr_i  in  paddr_width_p-3  Wishbone dword address.
- dat_i  in  64  Wishbone write data.
- dat_o  out  64  Wishbone read data.
- sel_i  in  8  byte lane select.
- we_i, cyc_i, stb_i  in  1 each  Wishbone classic control.
- ack_o, err_o  out  1 each  Wishbone termination.
- mem_cmd_o  out  cce_mem_msg_width_lp  BP command (bp_cce_mem_msg_s).
- mem_cmd_v_o  out  1  command valid.
- mem_cmd_ready_i  in  1  BP accepts command.
- mem_resp_i  in  cce_mem_msg_width_lp  BP response.
- mem_resp_v_i  in  1  response valid.
- mem_resp_yumi_o  out  1  response consumed.

Function
REQ-005 SHALL implement FSM states IDLE, SEND, WAIT, DONE.
REQ-006 IDLE: when cyc_i&stb_i, SHALL register the address, data, sel and we; go to SEND if sel_i is legal, else to DONE with error flagged.
REQ-007 Legal sel_i SHALL be exactly one of:
- one bit set (size 1);
- aligned pair 0x03/0x0C/0x30/0xC0 (size 2);
- 0x0F/0xF0 (size 4);
- 0xFF (size 8).
REQ-008 Byte offset SHALL be the index of the lowest set sel bit; cmd addr = {adr, offset}.
REQ-009 Cmd msg_type SHALL be e_cce_mem_uc_wr if we else e_cce_mem_uc_rd; size SHALL be the encoding of the byte count (1/2/4/8 -> 0/1/2/3); payload SHALL use lce_id_p.
REQ-010 Write data SHALL be dat_i shifted right by offset*8 (LSB-aligned), zero-extended to the block width.
REQ-011 SEND: mem_cmd_v_o=1 with mem_cmd_o held stable; on mem_cmd_ready_i go to WAIT.
REQ-012 WAIT: mem_resp_yumi_o = mem_resp_v_i; on mem_resp_v_i latch the resp data[63:0] shifted left by offset*8 into dat_o, zero unselected lanes, go to DONE.
REQ-013 DONE: exactly one cycle of ack_o=1 (or err_o=1 if flagged), then IDLE; ack_o and err_o SHALL never be simultaneous.
REQ-014 SHALL start a cycle counter on entry to SEND; if it reaches timeout_cycles_p before a response, go to DONE with err_o, and drop mem_cmd_v_o if still in SEND.
REQ-015 If cyc_i deasserts during SEND/WAIT, the BP transaction SHALL still complete (response consumed) but ack_o/err_o SHALL be suppressed.
REQ-016 Unsolicited mem_resp_v_i outside WAIT SHALL be ignored (yumi=0).
REQ-017 Minimum latency stb->ack SHALL be 3 cycles (ready and resp_v both immediate).
REQ-018 At most one outstanding command.

Reset
REQ-019 On reset_n_i low, SHALL asynchronously clear to IDLE: ack_o=0, err_o=0, mem_cmd_v_o=0, mem_resp_yumi_o=0, dat_o=0, counter=0, flags=0.
REQ-020 Reset mid-transaction SHALL abandon it; a stale response after release SHALL be dropped per REQ-016.

Structure
REQ-021 The size encoding and sel-legality function SHALL live in a shared package bp2wb_pkg, with the state enum, reusable by bp2wb_convertor.
REQ-022 SHALL contain one sub-module, wb_sel_decode (sel -> legal, offset, size), combinational.

Verification
REQ-023 Read sel=0xFF, adr=0x0E000000, immediate ready/resp data 0x1122334455667788 -> uc_rd, addr 0x70000000, size 3; ack at cycle 3; dat_o=0x1122334455667788.
REQ-024 Write sel=0x30, dat_i=0x0000BEEF00000000 -> uc_wr, addr low bits 4, size 1, data 0xBEEF; ack once.
REQ-025 Read sel=0x05 -> no mem_cmd_v_o; err_o one cycle.
REQ-026 Resp withheld 1024 cycles -> err_o at timeout; mem_cmd_v_o low; late resp ignored.
REQ-027 Read sel=0x0F with resp data 0xAABBCCDD after ready is stalled 5 cycles -> cmd stable throughout the stall; dat_o=0x00000000AABBCCDD; yumi pulses one cycle.
REQ-028 reset_n_i low during WAIT -> all outputs 0 immediately; the next transaction completes normally.
